// File: rtl/llr_buffer.sv
// Frame buffer for channel LLRs: fills LANES LLRs per beat at fixed addresses,
// holds the complete frame until released, and serves NRD registered read ports.
module llr_buffer #(
  parameter int unsigned LLR_W = 8,
  parameter int unsigned LANES = 8,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned NRD   = 2,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [LANES*LLR_W-1:0] i_in_data,
  input  logic                   i_release,
  output logic                   o_full,
  output logic                   o_frame_done,
  output logic [AW:0]            o_count,
  input  logic [NRD*AW-1:0]      i_rd_pos,
  output logic [NRD*LLR_W-1:0]   o_rd_data
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [AW:0] LAST_BASE = (AW+1)'(DEPTH - LANES);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LANE_CNT  = (AW+1)'(LANES);

  state_t           state, state_nxt;
  logic [AW:0]      count, count_nxt;
  logic             frame_done, frame_done_nxt;
  logic             accept;

  logic [LLR_W-1:0] mem   [DEPTH];
  logic [LLR_W-1:0] rd_q  [NRD];
  logic [AW-1:0]    rd_addr [NRD];
  logic             rd_ok [NRD];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= FILL;
      count      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    frame_done_nxt = 1'b0;
    accept         = 1'b0;
    case (state)
      FILL: begin
        if (i_in_valid) begin
          accept = 1'b1;
          if (count == LAST_BASE) begin
            state_nxt      = FULL;
            count_nxt      = FULL_CNT;
            frame_done_nxt = 1'b1;
          end else begin
            count_nxt = count + LANE_CNT;
          end
        end
      end
      FULL: begin
        if (i_release) begin
          state_nxt = FILL;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = FILL;
        count_nxt = '0;
      end
    endcase
  end

  // Addresses beyond DEPTH only exist when DEPTH is not a power of two; they read as 0.
  always_comb begin
    for (int unsigned p = 0; p < NRD; p++) begin
      rd_addr[p] = i_rd_pos[p*AW +: AW];
      rd_ok[p]   = (32'(rd_addr[p]) < DEPTH);
    end
  end

  // Non-blocking update gives read-before-write on a same-address collision.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      for (int unsigned p = 0; p < NRD; p++) begin
        rd_q[p] <= '0;
      end
    end else begin
      if (accept) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          mem[count[AW-1:0] + AW'(k)] <= i_in_data[k*LLR_W +: LLR_W];
        end
      end
      for (int unsigned p = 0; p < NRD; p++) begin
        rd_q[p] <= rd_ok[p] ? mem[rd_addr[p]] : '0;
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NRD; p++) begin
      o_rd_data[p*LLR_W +: LLR_W] = rd_q[p];
    end
  end

  assign o_in_ready   = (state == FILL);
  assign o_full       = (state == FULL);
  assign o_count      = count;
  assign o_frame_done = frame_done;

endmodule
